// File: rtl/arb_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
package arb_pkg;

    // Default limit on consecutive cycles a single owner may keep the grant.
    localparam int MAX_HOLD_DEFAULT = 8;

    // Arbiter controller states; encodings are fixed so debug traces stay stable.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT   = 2'b01,
        RELEASE = 2'b10
    } state_t;

endpackage

// File: rtl/rr_prioridad.sv
// Rotating-priority search: starting at ptr, the first asserted request wins.
// Purely combinational; the pointer lives in the arbiter.
module rr_prioridad #(
    parameter int N = 2
) (
    input  logic [(2**N)-1:0] req,
    input  logic [N-1:0]      ptr,
    output logic              valid,
    output logic [N-1:0]      winner
);

    localparam int NREQ = 2**N;

    logic [N-1:0] idx;

    // Scan ptr, ptr+1, ... (mod NREQ) and keep the first hit.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no
        // path through the block can leave it unassigned and infer a latch.
        valid  = 1'b0;
        winner = ptr;
        idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = ptr + N'(i);
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/arbitro_rr4.sv
// Four-requester round-robin arbiter with a bounded hold time.
// A grant lasts while the owner keeps requesting, up to MAX_HOLD cycles; every
// grant ends with one dead cycle before the next arbitration.
module arbitro_rr4
    import arb_pkg::*;
#(
    parameter int N        = 2,
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [(2**N)-1:0]   req,
    output logic [(2**N)-1:0]   gnt,
    output logic [N-1:0]        gnt_id,
    output logic                busy,
    output logic                timeout
);

    localparam int NREQ   = 2**N;
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t              state_q, state_d;
    logic [N-1:0]        ptr_q, ptr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [N-1:0]        gnt_id_q, gnt_id_d;
    logic                timeout_q, timeout_d;

    logic                arb_valid;
    logic [N-1:0]        arb_winner;

    rr_prioridad #(.N(N)) u_rr_prioridad (
        .req    (req),
        .ptr    (ptr_q),
        .valid  (arb_valid),
        .winner (arb_winner)
    );

    // Next-state logic: arbitrate from IDLE/RELEASE, track ownership in GRANT.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        timeout_d = 1'b0;

        case (state_q)
            IDLE, RELEASE: begin
                gnt_d = '0;
                if (arb_valid) begin
                    state_d  = GRANT;
                    gnt_d    = NREQ'(1) << arb_winner;
                    gnt_id_d = arb_winner;
                    // Wraps naturally in N bits, so the last index rolls to 0.
                    ptr_d    = arb_winner + N'(1);
                    hold_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end

            GRANT: begin
                if (!req[gnt_id_q]) begin
                    // Owner let go voluntarily: no timeout.
                    state_d = RELEASE;
                    gnt_d   = '0;
                end else if (hold_q == HOLD_LAST) begin
                    // Owner still requesting but has used its full slot.
                    state_d   = RELEASE;
                    gnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State registers; reset clears everything, including the pointer, at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples the
            // pre-edge values, independent of statement order.
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = (state_q == GRANT);
    assign timeout = timeout_q;

endmodule

// File: doc/arbitro_rr4.md
ARBITRO_RR4 -- requirements
Module: arbitro_rr4

Interface
REQ-001 The block SHALL have parameter N, default 2, meaning the width of the round-robin pointer and grant index (4 requesters).
REQ-002 The block SHALL have parameter MAX_HOLD, default 8, meaning the maximum consecutive cycles one owner may hold the grant.
REQ-003 The block SHALL have port clk  input  1  system clock; all state updates on posedge clk.
REQ-004 The block SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port req  input  4  request lines, one per requester, level-sensitive.
REQ-006 The block SHALL have port gnt  output  4  registered one-hot grant; all zeros when no owner.
REQ-007 The block SHALL have port gnt_id  output  N  registered index of the current or last owner.
REQ-008 The block SHALL have port busy  output  1  high while in state GRANT.
REQ-009 The block SHALL have port timeout  output  1  one-cycle registered pulse when a grant is revoked by MAX_HOLD.

Function
REQ-010 The FSM SHALL have states IDLE, GRANT and RELEASE.
REQ-011 Arbitration SHALL search req starting at index ptr, then ptr+1, ptr+2, ptr+3, all mod 4; the first set bit wins.
REQ-012 In IDLE, when req is nonzero at a clock edge, the FSM SHALL enter GRANT with gnt set to the winner's one-hot value, giving 1-cycle latency.
REQ-013 On every grant, ptr SHALL load winner+1 with 2-bit wrap (3 -> 0); ptr SHALL NOT change otherwise.
REQ-014 In GRANT, a hold counter SHALL count cycles from 0; gnt, gnt_id and the owner SHALL remain stable.
REQ-015 In GRANT, if req[owner] is sampled low, the FSM SHALL go to RELEASE with timeout staying 0.
REQ-016 In GRANT, if req[owner] is high and the hold counter equals MAX_HOLD-1, the FSM SHALL go to RELEASE and assert timeout during the RELEASE cycle only.
REQ-017 In RELEASE, gnt SHALL be 0 and busy 0 (one dead cycle); at the next edge the FSM SHALL arbitrate as in IDLE: go to GRANT if req is nonzero, else IDLE.
REQ-018 Changes on non-owner req bits during GRANT SHALL have no effect until arbitration.
REQ-019 A timed-out requester that still requests SHALL lose to any other requester because of the ptr rotation, and SHALL win only if it is the sole requester.
REQ-020 gnt SHALL be one-hot or zero at all times; gnt nonzero SHALL imply busy=1.
REQ-021 The hold counter width SHALL be clog2(MAX_HOLD), and the counter SHALL clear on every entry to GRANT.

Reset
REQ-022 With reset low, the following SHALL hold immediately, independent of clk: state=IDLE, ptr=0, gnt=0, gnt_id=0, busy=0, timeout=0, hold counter=0.
REQ-023 Reset asserted mid-grant SHALL drop gnt in the same cycle; after release, requester 0 SHALL have first priority.
REQ-024 Reset deassertion SHALL be synchronous to clk; the first arbitration SHALL occur at the first posedge with reset high.

Structure
REQ-025 The state encodings (IDLE=2'b00, GRANT=2'b01, RELEASE=2'b10) and the default MAX_HOLD SHALL reside in the shared package arb_pkg.
REQ-026 The rotating priority search SHALL be the combinational sub-module rr_prioridad (inputs req and ptr; outputs valid and winner index).
REQ-027 ptr, the hold counter and the FSM SHALL be registers in arbitro_rr4; the sub-module SHALL contain no storage.

Verification
REQ-028 Basic grant: reset release, req=4'b0100 -> next cycle gnt=4'b0100, gnt_id=2, busy=1; drop req -> RELEASE with gnt=0, then IDLE.
REQ-029 Rotation: req=4'b1111 held, MAX_HOLD=8 -> grants in order 0,1,2,3,0, each 8 cycles long, separated by 1 dead cycle, with timeout=1 in each dead cycle.
REQ-030 Wrap: owner 3 releases while req=4'b0011 -> next grant to 0, ptr=1.
REQ-031 Sole requester timeout: req=4'b0010 held -> gnt=4'b0010 for 8 cycles, then 1 dead cycle with timeout=1, then re-grant to 1.
REQ-032 Mid-grant reset: reset low while gnt=4'b1000 -> gnt=0 at once; after release with req=4'b1001, grant goes to 0.
REQ-033 Non-owner noise: while owner 2 is held, toggle req[0] and req[3] every cycle -> gnt stays 4'b0100 until req[2] drops.
